// File: rtl/prbs31_lock_checker_pkg.sv
// Shared constants, types and helpers for the PRBS31 lock checker.
package prbs31_lock_checker_pkg;

    // PRBS31 polynomial x^31 + x^28 + 1 expressed as shift-register taps
    localparam int unsigned PRBS31_TAP_A = 30;
    localparam int unsigned PRBS31_TAP_B = 27;
    localparam int unsigned PRBS31_LEN   = 31;

    localparam int unsigned SEED_CNT_W = 5;
    localparam int unsigned MATCH_W    = 16;
    localparam int unsigned STAT_W     = 32;
    localparam int unsigned LOSS_W     = 16;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    // Predictor either loads received bits or free-runs on its own prediction
    typedef enum logic {
        PRED_LOAD_RX  = 1'b0,
        PRED_FREE_RUN = 1'b1
    } pred_mode_t;

    typedef struct packed {
        logic [STAT_W-1:0] total_bits;
        logic [STAT_W-1:0] total_bit_errors;
        logic [LOSS_W-1:0] lock_loss_count;
    } chk_stats_t;

    // Saturating increment, holds at all-ones
    function automatic logic [STAT_W-1:0] sat_inc32(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    function automatic logic [LOSS_W-1:0] sat_inc16(input logic [LOSS_W-1:0] v);
        return (&v) ? v : v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/prbs31_lock_checker_if.sv
// Stream-in / statistics-out bundle of the PRBS31 lock checker.
interface prbs31_lock_checker_if;
    import prbs31_lock_checker_pkg::*;

    logic              clear;
    logic              data_in;
    logic              data_in_valid;
    logic              locked;
    logic [1:0]        state_out;
    logic [STAT_W-1:0] total_bits;
    logic [STAT_W-1:0] total_bit_errors;
    logic [LOSS_W-1:0] lock_loss_count;
    logic              error_pulse;

    // Stream source / statistics consumer side
    modport master (
        output clear, data_in, data_in_valid,
        input  locked, state_out, total_bits, total_bit_errors,
               lock_loss_count, error_pulse
    );

    // Checker side
    modport slave (
        input  clear, data_in, data_in_valid,
        output locked, state_out, total_bits, total_bit_errors,
               lock_loss_count, error_pulse
    );
endinterface

// File: rtl/prbs31_lock_checker_predictor.sv
// PRBS31 reference shift register: loads received bits or free-runs, exposes next-bit prediction.
module prbs31_lock_checker_predictor
    import prbs31_lock_checker_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  pred_mode_t mode,
    input  logic       din,
    output logic       p_c,
    output logic       sr_zero_c
);

    logic [PRBS31_LEN-1:0] sr_q;
    logic [PRBS31_LEN-1:0] sr_d;

    assign p_c       = sr_q[PRBS31_TAP_A] ^ sr_q[PRBS31_TAP_B];
    assign sr_zero_c = (sr_q == '0);

    // Shift in either the received bit (self-sync) or the prediction (free-run)
    always_comb begin
        sr_d = sr_q;
        if (en) begin
            sr_d = {sr_q[PRBS31_LEN-2:0], (mode == PRED_FREE_RUN) ? p_c : din};
        end
    end

    // Reference register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/prbs31_lock_checker.sv
// Self-synchronising PRBS31 checker: seeds from the stream, verifies, locks,
// then counts bits/errors and drops lock when a window sees too many errors.
module prbs31_lock_checker
    import prbs31_lock_checker_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 64,
    parameter int unsigned WINDOW_LEN  = 1024,
    parameter int unsigned LOSS_THRESH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    prbs31_lock_checker_if.slave bus
);

    localparam int unsigned WIN_W = $clog2(WINDOW_LEN + 1);

    chk_state_t              state_q,       state_d;
    logic [SEED_CNT_W-1:0]   seed_cnt_q,    seed_cnt_d;
    logic [MATCH_W-1:0]      match_cnt_q,   match_cnt_d;
    logic [WIN_W-1:0]        win_bits_q,    win_bits_d;
    logic [WIN_W-1:0]        win_err_q,     win_err_d;
    chk_stats_t              stats_q,       stats_d;
    logic                    error_pulse_q, error_pulse_d;
    logic                    locked_q,      locked_d;

    pred_mode_t              pred_mode_c;
    logic                    pred_c;
    logic                    sr_zero_c;
    logic                    bit_err_c;
    logic [WIN_W-1:0]        win_bits_nx_c;
    logic [WIN_W-1:0]        win_err_nx_c;

    assign pred_mode_c   = (state_q == ST_LOCKED) ? PRED_FREE_RUN : PRED_LOAD_RX;
    assign bit_err_c     = bus.data_in ^ pred_c;
    assign win_bits_nx_c = win_bits_q + WIN_W'(1);
    assign win_err_nx_c  = win_err_q + WIN_W'(bit_err_c);

    prbs31_lock_checker_predictor u_pred (
        .clk       (clk),
        .rst       (rst),
        .en        (bus.data_in_valid),
        .mode      (pred_mode_c),
        .din       (bus.data_in),
        .p_c       (pred_c),
        .sr_zero_c (sr_zero_c)
    );

    // Lock FSM, seed/match/window counters and statistics
    always_comb begin
        state_d       = state_q;
        seed_cnt_d    = seed_cnt_q;
        match_cnt_d   = match_cnt_q;
        win_bits_d    = win_bits_q;
        win_err_d     = win_err_q;
        stats_d       = stats_q;
        error_pulse_d = 1'b0;

        if (bus.data_in_valid) begin
            case (state_q)
                ST_SEED: begin
                    seed_cnt_d = seed_cnt_q + SEED_CNT_W'(1);
                    if (seed_cnt_q == SEED_CNT_W'(PRBS31_LEN - 1)) begin
                        state_d     = ST_VERIFY;
                        seed_cnt_d  = '0;
                        match_cnt_d = '0;
                    end
                end

                ST_VERIFY: begin
                    if (bit_err_c) begin
                        match_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                        if (match_cnt_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            match_cnt_d = '0;
                            // An all-zero register predicts zeros forever: not a real lock
                            if (sr_zero_c) begin
                                state_d    = ST_SEED;
                                seed_cnt_d = '0;
                            end else begin
                                state_d    = ST_LOCKED;
                                win_bits_d = '0;
                                win_err_d  = '0;
                            end
                        end
                    end
                end

                ST_LOCKED: begin
                    stats_d.total_bits = sat_inc32(stats_q.total_bits);
                    if (bit_err_c) begin
                        stats_d.total_bit_errors = sat_inc32(stats_q.total_bit_errors);
                        error_pulse_d            = 1'b1;
                    end
                    // Loss is judged including this bit; otherwise the window may roll over
                    if (win_err_nx_c == WIN_W'(LOSS_THRESH)) begin
                        state_d                 = ST_SEED;
                        seed_cnt_d              = '0;
                        stats_d.lock_loss_count = sat_inc16(stats_q.lock_loss_count);
                    end else if (win_bits_nx_c == WIN_W'(WINDOW_LEN)) begin
                        win_bits_d = '0;
                        win_err_d  = '0;
                    end else begin
                        win_bits_d = win_bits_nx_c;
                        win_err_d  = win_err_nx_c;
                    end
                end

                default: begin
                    state_d    = ST_SEED;
                    seed_cnt_d = '0;
                end
            endcase
        end

        // Clear overrides any same-cycle increment; FSM and window untouched
        if (bus.clear) begin
            stats_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SEED;
            seed_cnt_q    <= '0;
            match_cnt_q   <= '0;
            win_bits_q    <= '0;
            win_err_q     <= '0;
            stats_q       <= '0;
            error_pulse_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            seed_cnt_q    <= seed_cnt_d;
            match_cnt_q   <= match_cnt_d;
            win_bits_q    <= win_bits_d;
            win_err_q     <= win_err_d;
            stats_q       <= stats_d;
            error_pulse_q <= error_pulse_d;
            locked_q      <= locked_d;
        end
    end

    assign bus.locked           = locked_q;
    assign bus.state_out        = state_q;
    assign bus.total_bits       = stats_q.total_bits;
    assign bus.total_bit_errors = stats_q.total_bit_errors;
    assign bus.lock_loss_count  = stats_q.lock_loss_count;
    assign bus.error_pulse      = error_pulse_q;

endmodule

// File: tb/tb_prbs31_lock_checker.sv
// Randomised self-checking bench for prbs31_lock_checker with a bit-history reference model.
module tb_prbs31_lock_checker;

    localparam int LOCK_COUNT  = 64;
    localparam int WINDOW_LEN  = 1024;
    localparam int LOSS_THRESH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prbs31_lock_checker_if bus ();

    prbs31_lock_checker #(
        .LOCK_COUNT  (LOCK_COUNT),
        .WINDOW_LEN  (WINDOW_LEN),
        .LOSS_THRESH (LOSS_THRESH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: history of the last 31 reference bits, oldest first
    bit          m_hist[$];
    int          m_state, m_seed, m_match, m_wbits, m_werr;
    logic [31:0] m_tb, m_te;
    logic [15:0] m_ll;
    logic        m_pulse;
    logic        m_locked;

    // Transmit-side PRBS31 generator history
    bit tx_hist[$];

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < 31; i++) m_hist.push_back(1'b0);
        m_state = 0; m_seed = 0; m_match = 0; m_wbits = 0; m_werr = 0;
        m_tb = '0; m_te = '0; m_ll = '0; m_pulse = 1'b0; m_locked = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit c);
        bit p;
        bit allz;
        m_pulse = 1'b0;
        if (v) begin
            // bit n predicted from bits n-31 and n-28
            p = m_hist[0] ^ m_hist[3];
            void'(m_hist.pop_front());
            case (m_state)
                0: begin
                    m_hist.push_back(d);
                    m_seed++;
                    if (m_seed == 31) begin m_state = 1; m_match = 0; end
                end
                1: begin
                    m_hist.push_back(d);
                    if (d == p) begin
                        m_match++;
                        if (m_match == LOCK_COUNT) begin
                            allz = 1'b1;
                            foreach (m_hist[i]) if (m_hist[i]) allz = 1'b0;
                            m_match = 0;
                            if (allz) begin m_state = 0; m_seed = 0; end
                            else begin m_state = 2; m_wbits = 0; m_werr = 0; end
                        end
                    end else begin
                        m_match = 0;
                    end
                end
                default: begin
                    m_hist.push_back(p);
                    if (m_tb != 32'hFFFF_FFFF) m_tb++;
                    if (d != p) begin
                        if (m_te != 32'hFFFF_FFFF) m_te++;
                        m_werr++;
                        m_pulse = 1'b1;
                    end
                    m_wbits++;
                    if (m_werr == LOSS_THRESH) begin
                        m_state = 0; m_seed = 0;
                        if (m_ll != 16'hFFFF) m_ll++;
                    end else if (m_wbits == WINDOW_LEN) begin
                        m_wbits = 0; m_werr = 0;
                    end
                end
            endcase
        end
        if (c) begin m_tb = '0; m_te = '0; m_ll = '0; end
        m_locked = (m_state == 2);
    endtask

    task automatic tx_init(input logic [30:0] seed);
        tx_hist = {};
        for (int i = 0; i < 31; i++) tx_hist.push_back(seed[30-i]);
    endtask

    task automatic tx_next(output bit b);
        b = tx_hist[0] ^ tx_hist[3];
        void'(tx_hist.pop_front());
        tx_hist.push_back(b);
    endtask

    // Called at posedge+1; returns at the next posedge+1
    task automatic drive(input bit v, input bit d, input bit c);
        bus.data_in_valid = v;
        bus.data_in       = d;
        bus.clear         = c;
        model_step(v, d, c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.data_in_valid = 1'b0;
        bus.data_in       = 1'b0;
        bus.clear         = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic lock_up();
        bit b;
        do_reset();
        tx_init(31'($urandom()) | 31'd1);
        for (int i = 0; i < 100; i++) begin tx_next(b); drive(1'b1, b, 1'b0); end
    endtask

    task automatic test_reset();
        bus.data_in_valid = 1'b1; bus.data_in = 1'b1; bus.clear = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got=%0h exp=0", bus.locked); else n_pass++;
        n_checks++; if (bus.state_out !== 2'd0) $display("FAIL reset_state got=%0h exp=0", bus.state_out); else n_pass++;
        n_checks++; if (bus.total_bits !== 32'd0) $display("FAIL reset_total_bits got=%0h exp=0", bus.total_bits); else n_pass++;
        n_checks++; if (bus.total_bit_errors !== 32'd0) $display("FAIL reset_errors got=%0h exp=0", bus.total_bit_errors); else n_pass++;
        n_checks++; if (bus.lock_loss_count !== 16'd0) $display("FAIL reset_loss got=%0h exp=0", bus.lock_loss_count); else n_pass++;
        n_checks++; if (bus.error_pulse !== 1'b0) $display("FAIL reset_pulse got=%0h exp=0", bus.error_pulse); else n_pass++;
        do_reset();
    endtask

    task automatic test_lock_continuous();
        bit b;
        int lock_at = -1;
        do_reset();
        tx_init(31'h7FFF_FFFF);
        for (int i = 1; i <= 200; i++) begin
            tx_next(b);
            drive(1'b1, b, 1'b0);
            if (bus.locked === 1'b1 && lock_at < 0) lock_at = i;
            n_checks++;
            if (bus.locked !== m_locked || bus.state_out !== 2'(m_state))
                $display("FAIL lock_cont_bit%0d got=%0h/%0h exp=%0h/%0h", i, bus.locked, bus.state_out, m_locked, m_state);
            else n_pass++;
        end
        n_checks++; if (lock_at !== 95) $display("FAIL lock_cont_point got=%0d exp=95", lock_at); else n_pass++;
        n_checks++; if (bus.total_bit_errors !== 32'd0) $display("FAIL lock_cont_errors got=%0d exp=0", bus.total_bit_errors); else n_pass++;
        n_checks++; if (bus.total_bits !== 32'd105) $display("FAIL lock_cont_bits got=%0d exp=105", bus.total_bits); else n_pass++;
    endtask

    task automatic test_single_error();
        bit b;
        int pulses = 0;
        int unlocked = 0;
        lock_up();
        for (int i = 0; i < 41; i++) begin
            tx_next(b);
            drive(1'b1, (i == 20) ? ~b : b, 1'b0);
            if (bus.error_pulse === 1'b1) pulses++;
            if (bus.locked !== 1'b1) unlocked++;
            if (i == 20) begin
                n_checks++; if (bus.error_pulse !== 1'b1) $display("FAIL single_pulse_timing got=%0h exp=1", bus.error_pulse); else n_pass++;
            end
        end
        n_checks++; if (bus.total_bit_errors !== 32'd1) $display("FAIL single_errors got=%0d exp=1", bus.total_bit_errors); else n_pass++;
        n_checks++; if (pulses !== 1) $display("FAIL single_pulses got=%0d exp=1", pulses); else n_pass++;
        n_checks++; if (unlocked !== 0) $display("FAIL single_lock_held got=%0d exp=0", unlocked); else n_pass++;
        n_checks++; if (bus.total_bits !== 32'd46) $display("FAIL single_bits got=%0d exp=46", bus.total_bits); else n_pass++;
    endtask

    task automatic test_loss_relock();
        bit b;
        int relock_at = -1;
        lock_up();
        for (int k = 1; k <= 64; k++) begin
            tx_next(b);
            drive(1'b1, ~b, 1'b0);
            n_checks++;
            if (bus.locked !== ((k < 64) ? 1'b1 : 1'b0))
                $display("FAIL loss_locked_k%0d got=%0h exp=%0h", k, bus.locked, (k < 64));
            else n_pass++;
        end
        n_checks++; if (bus.lock_loss_count !== 16'd1) $display("FAIL loss_count got=%0d exp=1", bus.lock_loss_count); else n_pass++;
        n_checks++; if (bus.total_bit_errors !== 32'd64) $display("FAIL loss_errors got=%0d exp=64", bus.total_bit_errors); else n_pass++;
        for (int j = 1; j <= 200 && relock_at < 0; j++) begin
            tx_next(b);
            drive(1'b1, b, 1'b0);
            if (bus.locked === 1'b1) relock_at = j;
        end
        n_checks++; if (relock_at !== 95) $display("FAIL loss_relock_point got=%0d exp=95", relock_at); else n_pass++;
    endtask

    task automatic test_all_zero();
        int ever_locked = 0;
        int returns = 0;
        logic [1:0] prev = 2'd0;
        do_reset();
        for (int i = 1; i <= 200; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (bus.locked === 1'b1) ever_locked++;
            if (prev == 2'd1 && bus.state_out == 2'd0) returns++;
            prev = bus.state_out;
            n_checks++;
            if (bus.state_out !== 2'(m_state)) $display("FAIL zero_state_bit%0d got=%0h exp=%0h", i, bus.state_out, m_state); else n_pass++;
        end
        n_checks++; if (ever_locked !== 0) $display("FAIL zero_locked got=%0d exp=0", ever_locked); else n_pass++;
        n_checks++; if (returns !== 2) $display("FAIL zero_cycles got=%0d exp=2", returns); else n_pass++;
        n_checks++; if (bus.total_bits !== 32'd0 || bus.total_bit_errors !== 32'd0 || bus.lock_loss_count !== 16'd0)
            $display("FAIL zero_counters got=%0d/%0d/%0d exp=0/0/0", bus.total_bits, bus.total_bit_errors, bus.lock_loss_count);
        else n_pass++;
    endtask

    task automatic test_sparse_valid();
        bit b;
        int vcnt = 0;
        int lock_v = -1;
        do_reset();
        tx_init(31'($urandom()) | 31'd1);
        for (int cyc = 0; vcnt < 150 && cyc < 1000; cyc++) begin
            if (cyc % 3 == 0) begin
                tx_next(b);
                vcnt++;
                drive(1'b1, b, 1'b0);
            end else begin
                drive(1'b0, 1'($urandom_range(1)), 1'b0);
            end
            if (bus.locked === 1'b1 && lock_v < 0) lock_v = vcnt;
            n_checks++;
            if (bus.locked !== m_locked || bus.error_pulse !== 1'b0)
                $display("FAIL sparse_cyc%0d got=%0h/%0h exp=%0h/0", cyc, bus.locked, bus.error_pulse, m_locked);
            else n_pass++;
        end
        n_checks++; if (lock_v !== 95) $display("FAIL sparse_lock_point got=%0d exp=95", lock_v); else n_pass++;
        n_checks++; if (bus.total_bits !== 32'd55) $display("FAIL sparse_bits got=%0d exp=55", bus.total_bits); else n_pass++;
    endtask

    task automatic test_clear();
        bit b;
        lock_up();
        for (int k = 0; k < 64; k++) begin tx_next(b); drive(1'b1, ~b, 1'b0); end
        for (int j = 0; j < 110; j++) begin tx_next(b); drive(1'b1, b, 1'b0); end
        n_checks++; if (bus.lock_loss_count !== 16'd1 || bus.locked !== 1'b1)
            $display("FAIL clear_setup got=%0d/%0h exp=1/1", bus.lock_loss_count, bus.locked);
        else n_pass++;
        tx_next(b);
        drive(1'b1, ~b, 1'b1);
        n_checks++; if (bus.total_bits !== 32'd0) $display("FAIL clear_bits got=%0d exp=0", bus.total_bits); else n_pass++;
        n_checks++; if (bus.total_bit_errors !== 32'd0) $display("FAIL clear_errors got=%0d exp=0", bus.total_bit_errors); else n_pass++;
        n_checks++; if (bus.lock_loss_count !== 16'd0) $display("FAIL clear_loss got=%0d exp=0", bus.lock_loss_count); else n_pass++;
        n_checks++; if (bus.locked !== 1'b1) $display("FAIL clear_fsm got=%0h exp=1", bus.locked); else n_pass++;
        tx_next(b);
        drive(1'b1, b, 1'b0);
        n_checks++; if (bus.total_bits !== 32'd1) $display("FAIL clear_resume got=%0d exp=1", bus.total_bits); else n_pass++;
    endtask

    task automatic test_random();
        bit b;
        bit v, e, c, d;
        int dens[4] = '{25, 2, 1000, 18};
        do_reset();
        tx_init(31'($urandom()) | 31'd1);
        for (int s = 0; s < 4; s++) begin
            for (int cyc = 0; cyc < 2500; cyc++) begin
                v = ($urandom_range(3) != 0);
                b = 1'b0;
                if (v) tx_next(b);
                e = (m_state == 2) && ($urandom_range(dens[s] - 1) == 0);
                c = ($urandom_range(299) == 0);
                d = v ? (b ^ e) : 1'($urandom_range(1));
                drive(v, d, c);
                n_checks++; if (bus.locked !== m_locked) $display("FAIL rnd_locked s%0d c%0d got=%0h exp=%0h", s, cyc, bus.locked, m_locked); else n_pass++;
                n_checks++; if (bus.state_out !== 2'(m_state)) $display("FAIL rnd_state s%0d c%0d got=%0h exp=%0h", s, cyc, bus.state_out, m_state); else n_pass++;
                n_checks++; if (bus.total_bits !== m_tb) $display("FAIL rnd_bits s%0d c%0d got=%0d exp=%0d", s, cyc, bus.total_bits, m_tb); else n_pass++;
                n_checks++; if (bus.total_bit_errors !== m_te) $display("FAIL rnd_errors s%0d c%0d got=%0d exp=%0d", s, cyc, bus.total_bit_errors, m_te); else n_pass++;
                n_checks++; if (bus.lock_loss_count !== m_ll) $display("FAIL rnd_loss s%0d c%0d got=%0d exp=%0d", s, cyc, bus.lock_loss_count, m_ll); else n_pass++;
                n_checks++; if (bus.error_pulse !== m_pulse) $display("FAIL rnd_pulse s%0d c%0d got=%0h exp=%0h", s, cyc, bus.error_pulse, m_pulse); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit b;
        int relock_at = -1;
        lock_up();
        tx_next(b);
        drive(1'b1, ~b, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.locked !== 1'b0) $display("FAIL rstmid_locked got=%0h exp=0", bus.locked); else n_pass++;
        n_checks++; if (bus.state_out !== 2'd0) $display("FAIL rstmid_state got=%0h exp=0", bus.state_out); else n_pass++;
        n_checks++; if (bus.total_bits !== 32'd0) $display("FAIL rstmid_bits got=%0d exp=0", bus.total_bits); else n_pass++;
        n_checks++; if (bus.total_bit_errors !== 32'd0) $display("FAIL rstmid_errors got=%0d exp=0", bus.total_bit_errors); else n_pass++;
        n_checks++; if (bus.error_pulse !== 1'b0) $display("FAIL rstmid_pulse got=%0h exp=0", bus.error_pulse); else n_pass++;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 1; j <= 200 && relock_at < 0; j++) begin
            tx_next(b);
            drive(1'b1, b, 1'b0);
            if (bus.locked === 1'b1) relock_at = j;
        end
        n_checks++; if (relock_at !== 95) $display("FAIL rstmid_relock got=%0d exp=95", relock_at); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lock_continuous();
        test_single_error();
        test_loss_relock();
        test_all_zero();
        test_sparse_valid();
        test_clear();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
